silly_pattern_gen: RTL and testbench

//   Parametrised successor to the single-function silly pattern block. Drives a

---
 rtl/silly_pkg.sv | 31 +++
 rtl/silly_prescaler.sv | 27 ++
 rtl/silly_pattern_gen.sv | 129 ++++++++++++
 tb/tb_silly_pattern_gen.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/silly_pkg.sv
// Shared types and helpers for the silly pattern generator.
package silly_pkg;

  // Widest pattern the seed helper can describe.
  localparam int unsigned MaxWidth = 64;

  typedef enum logic [1:0] {
    ModeCount = 2'd0,
    ModeScan  = 2'd1,
    ModeLfsr  = 2'd2,
    ModeShift = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2
  } state_e;

  // Pattern loaded on entry to a mode; caller truncates to its own width.
  function automatic logic [MaxWidth-1:0] seed_of(mode_e mode, logic [MaxWidth-1:0] lfsr_seed);
    logic [MaxWidth-1:0] seed;
    case (mode)
      ModeScan: seed = MaxWidth'(1);
      ModeLfsr: seed = lfsr_seed;
      default:  seed = '0;
    endcase
    return seed;
  endfunction

endpackage

// File: rtl/silly_prescaler.sv
// Free-running divider: tick_o flags the cycle on which the count wraps at div_i.
module silly_prescaler #(
  parameter int unsigned DivW = 24
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic [DivW-1:0] div_i,
  output logic            tick_o
);

  logic [DivW-1:0] cnt_q;

  // Wrap event this cycle; the parent registers it alongside the pattern update.
  assign tick_o = en_i & ~clr_i & (cnt_q == div_i);

  // Count up to div_i then return to zero; clear wins over enable.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == div_i) ? '0 : cnt_q + DivW'(1);
    end
  end

endmodule

// File: rtl/silly_pattern_gen.sv
// Four-mode pattern generator (count, scan, LFSR, serial shift) advanced by a prescaler.
module silly_pattern_gen
  import silly_pkg::*;
#(
  parameter int unsigned      Width      = 8,
  parameter int unsigned      DivW       = 24,
  parameter logic [DivW-1:0]  DefaultDiv = DivW'(4_999_999),
  parameter logic [Width-1:0] LfsrTaps   = Width'(8'hB8),
  parameter logic [Width-1:0] LfsrSeed   = Width'(8'h01)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [1:0]       cfg_mode_i,
  input  logic [DivW-1:0]  cfg_div_i,
  input  logic             ser_in_i,
  output logic [Width-1:0] pat_out_o,
  output logic             tick_o,
  output logic             wrap_o
);

  state_e           state_q;
  mode_e            mode_q;
  logic [DivW-1:0]  div_q;
  logic [Width-1:0] pat_q;
  logic             dir_q;  // scan direction: 0 = up (towards MSB), 1 = down
  logic             tick_q;
  logic             wrap_q;

  logic [Width-1:0] seed;
  logic [Width-1:0] pat_nxt;
  logic             dir_nxt;
  logic             wrap_nxt;
  logic             accept;
  logic             ps_en;
  logic             ps_clr;
  logic             ps_tick;

  assign cfg_ready_o = (state_q != StLoad);
  assign accept      = cfg_valid_i & cfg_ready_o;
  // Prescaler freezes as soon as run drops, so the phase survives a pause.
  assign ps_en       = (state_q == StRun) & run_i;
  assign ps_clr      = (state_q == StLoad);
  assign seed        = Width'(seed_of(mode_q, MaxWidth'(LfsrSeed)));

  assign pat_out_o = pat_q;
  assign tick_o    = tick_q;
  assign wrap_o    = wrap_q;

  silly_prescaler #(
    .DivW (DivW)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (ps_en),
    .clr_i  (ps_clr),
    .div_i  (div_q),
    .tick_o (ps_tick)
  );

  // Next pattern under the currently latched mode.
  always_comb begin
    pat_nxt = pat_q;
    dir_nxt = dir_q;
    unique case (mode_q)
      ModeCount: pat_nxt = pat_q + Width'(1);
      ModeScan: begin
        if (!dir_q) begin
          pat_nxt = pat_q << 1;
          if (pat_nxt[Width-1]) dir_nxt = 1'b1;
        end else begin
          pat_nxt = pat_q >> 1;
          if (pat_nxt[0]) dir_nxt = 1'b0;
        end
      end
      ModeLfsr: begin
        // A zero state would lock up the LFSR, so reseed instead.
        if (pat_q == '0) pat_nxt = LfsrSeed;
        else             pat_nxt = (pat_q >> 1) ^ (pat_q[0] ? LfsrTaps : '0);
      end
      ModeShift: pat_nxt = {pat_q[Width-2:0], ser_in_i};
      default: ;
    endcase
    wrap_nxt = (mode_q != ModeShift) && (pat_nxt == seed);
  end

  // Control FSM, config registers and registered pattern/tick/wrap outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      mode_q  <= ModeCount;
      div_q   <= DefaultDiv;
      pat_q   <= '0;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      unique case (state_q)
        StIdle, StRun: begin
          if (accept) begin
            // Config wins: any tick this cycle is dropped with its update.
            state_q <= StLoad;
            mode_q  <= mode_e'(cfg_mode_i);
            div_q   <= cfg_div_i;
          end else begin
            if (ps_tick) begin
              pat_q  <= pat_nxt;
              dir_q  <= dir_nxt;
              tick_q <= 1'b1;
              wrap_q <= wrap_nxt;
            end
            state_q <= run_i ? StRun : StIdle;
          end
        end
        StLoad: begin
          pat_q   <= seed;
          dir_q   <= 1'b0;
          state_q <= run_i ? StRun : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_silly_pattern_gen.sv
// Bench for silly_pattern_gen: directed scenarios plus random traffic against a mode-level model.
module tb_silly_pattern_gen;

  localparam int W    = 8;
  localparam int DEF  = 3;
  localparam int TAPS = 'hB8;
  localparam int SEED = 'h01;

  logic        clk = 1'b0;
  logic        rst, run, cfg_valid, ser;
  logic [1:0]  cfg_mode;
  logic [23:0] cfg_div;
  logic        cfg_ready, tick, wrap;
  logic [7:0]  pat;

  int n_checks = 0;
  int n_err    = 0;

  silly_pattern_gen #(
    .Width      (W),
    .DivW       (24),
    .DefaultDiv (24'd3),
    .LfsrTaps   (8'hB8),
    .LfsrSeed   (8'h01)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .run_i       (run),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_mode_i  (cfg_mode),
    .cfg_div_i   (cfg_div),
    .ser_in_i    (ser),
    .pat_out_o   (pat),
    .tick_o      (tick),
    .wrap_o      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_valid = 0, m_run, m_load, m_tick, m_wrap;
  int m_mode, m_div, m_cnt, m_pat, m_k;

  // Scan position k in 0..2W-3 walks up to the MSB and back down.
  function automatic int scan_pat(int k);
    return 1 << ((k < W) ? k : 2 * W - 2 - k);
  endfunction

  task automatic model_step();
    if (rst) begin
      m_valid = 1; m_run = 0; m_load = 0; m_mode = 0; m_div = DEF;
      m_cnt = 0; m_pat = 0; m_k = 0; m_tick = 0; m_wrap = 0;
    end else if (m_valid) begin
      m_tick = 0; m_wrap = 0;
      if (m_load) begin
        m_load = 0; m_cnt = 0; m_k = 0;
        case (m_mode)
          1: m_pat = 1;
          2: m_pat = SEED;
          default: m_pat = 0;
        endcase
        m_run = run;
      end else if (cfg_valid) begin
        m_load = 1; m_mode = int'(cfg_mode); m_div = int'(cfg_div);
      end else begin
        if (m_run && run) begin
          if (m_cnt == m_div) begin
            m_cnt = 0; m_tick = 1;
            case (m_mode)
              0: begin m_pat = (m_pat + 1) % 256; m_wrap = (m_pat == 0); end
              1: begin m_k = (m_k + 1) % (2 * W - 2); m_pat = scan_pat(m_k); m_wrap = (m_k == 0); end
              2: begin
                if (m_pat == 0) m_pat = SEED;
                else m_pat = (m_pat >> 1) ^ (((m_pat & 1) != 0) ? TAPS : 0);
                m_wrap = (m_pat == SEED);
              end
              default: begin m_pat = ((m_pat << 1) | int'(ser)) & 255; m_wrap = 0; end
            endcase
          end else begin
            m_cnt++;
          end
        end
        m_run = run;
      end
    end
  endtask

  // Advance the model on each edge, then compare just after it.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (m_valid) begin
        check("model pat", 32'(pat), 32'(m_pat));
        check("model tick", 32'(tick), 32'(m_tick));
        check("model wrap", 32'(wrap), 32'(m_wrap));
        check("model cfg_ready", 32'(cfg_ready), 32'(!m_load));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_cfg(input logic [1:0] mode, input logic [23:0] div);
    cfg_valid = 1'b1; cfg_mode = mode; cfg_div = div;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Cycles from now until the first tick, bounded.
  task automatic cycles_to_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 40);
  endtask

  initial begin
    logic [7:0] scan_exp [14];
    logic [7:0] got [14];
    logic       gw [14];
    bit         seen [256];
    int n, nt, nw, nd;

    scan_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    rst = 1; run = 0; cfg_valid = 0; cfg_mode = 0; cfg_div = 0; ser = 0;
    repeat (2) @(negedge clk);
    check("reset pat", 32'(pat), 32'h0);
    check("reset cfg_ready", 32'(cfg_ready), 32'h1);
    check("reset tick", 32'(tick), 32'h0);
    check("reset wrap", 32'(wrap), 32'h0);
    rst = 0;

    // Default divisor: first tick DEF+1 cycles after RUN entry.
    run = 1;
    cycles_to_tick(n);
    check("first tick latency", 32'(n), 32'd5);
    check("first tick pat", 32'(pat), 32'h1);

    // COUNT, div=0: full wrap around.
    do_cfg(2'd0, 24'd0);
    @(negedge clk);
    check("count seed", 32'(pat), 32'h0);
    nw = 0;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (wrap) nw++;
      if (i == 255) check("count 255", 32'(pat), 32'hFF);
      if (i == 256) begin
        check("count wrap pat", 32'(pat), 32'h0);
        check("count wrap flag", 32'(wrap), 32'h1);
      end
    end
    check("count wrap total", 32'(nw), 32'd1);

    // SCAN, div=1: bounce with a tick every 2 cycles.
    do_cfg(2'd1, 24'd1);
    @(negedge clk);
    check("scan seed", 32'(pat), 32'h01);
    n = 0; nt = 0;
    while (nt < 14 && n < 60) begin
      @(negedge clk);
      n++;
      if (tick) begin got[nt] = pat; gw[nt] = wrap; nt++; end
    end
    check("scan tick count", 32'(nt), 32'd14);
    check("scan cycles", 32'(n), 32'd28);
    nw = 0;
    for (int i = 0; i < nt; i++) begin
      check($sformatf("scan step %0d", i), 32'(got[i]), 32'(scan_exp[i]));
      if (gw[i]) nw++;
    end
    check("scan wrap total", 32'(nw), 32'd1);
    check("scan wrap last", 32'(gw[13]), 32'h1);

    // LFSR, div=0: maximal length sequence.
    do_cfg(2'd2, 24'd0);
    @(negedge clk);
    check("lfsr seed", 32'(pat), 32'h01);
    for (int i = 0; i < 256; i++) seen[i] = 0;
    nw = 0; nd = 0;
    for (int i = 1; i <= 255; i++) begin
      @(negedge clk);
      if (!seen[pat]) nd++;
      seen[pat] = 1;
      if (wrap) nw++;
    end
    check("lfsr distinct", 32'(nd), 32'd255);
    check("lfsr never zero", 32'(seen[0]), 32'h0);
    check("lfsr back to seed", 32'(pat), 32'h01);
    check("lfsr wrap last", 32'(wrap), 32'h1);
    check("lfsr wrap total", 32'(nw), 32'd1);

    // cfg_valid held across LOAD: one accept.
    cfg_valid = 1; cfg_mode = 2'd3; cfg_div = 24'd0;
    @(negedge clk);
    check("held valid ready low", 32'(cfg_ready), 32'h0);
    @(negedge clk);
    check("held valid ready back", 32'(cfg_ready), 32'h1);
    check("shift seed", 32'(pat), 32'h0);
    cfg_valid = 0;
    ser = 1;
    repeat (3) @(negedge clk);
    check("shift in ones", 32'(pat), 32'h07);
    check("shift tick", 32'(tick), 32'h1);
    do_cfg(2'd3, 24'd0);
    check("cfg on tick: no tick", 32'(tick), 32'h0);
    check("cfg on tick: pat held", 32'(pat), 32'h07);
    @(negedge clk);
    check("cfg on tick: seed", 32'(pat), 32'h0);
    check("cfg on tick: load tick", 32'(tick), 32'h0);

    // Reset mid-run in SHIFT mode.
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("midrun reset pat", 32'(pat), 32'h0);
    check("midrun reset ready", 32'(cfg_ready), 32'h1);
    check("midrun reset tick", 32'(tick), 32'h0);
    rst = 0;
    cycles_to_tick(n);
    check("midrun reset div", 32'(n), 32'd5);
    check("midrun reset count mode", 32'(pat), 32'h1);

    // Pause mid-count: prescaler phase survives.
    do_cfg(2'd0, 24'd3);
    @(negedge clk);
    repeat (2) @(negedge clk);
    run = 0;
    nt = 0;
    repeat (5) begin
      @(negedge clk);
      if (tick) nt++;
    end
    check("pause no tick", 32'(nt), 32'd0);
    check("pause pat held", 32'(pat), 32'h0);
    run = 1;
    cycles_to_tick(n);
    check("resume remaining phase", 32'(n), 32'd3);
    check("resume pat", 32'(pat), 32'h1);

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 5000; i++) begin
      rst       = ($urandom_range(0, 399) == 0);
      run       = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 24) == 0);
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_div   = 24'($urandom_range(0, 3));
      ser       = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
